imem_stream_loader: RTL and testbench
=====================================

// Module: imem_stream_loader
// PURPOSE
//  Synthesizable instruction-memory boot loader for Top_Module_Pipe: replaces bench-driven preload.
//  Accepts a framed byte stream (valid/ready), assembles little-endian words, and writes them
//  through the imem preload port (we0/wr_addr0/wr_din0). Optionally verifies a checksum, then
//  releases the PC (resetpc=1). Word width, address width, base address and checksum are parametrised.
// PARAMETERS
//  XLEN        32   word width in bits; multiple of 8; bytes per word BPW = XLEN/8
//  ADDR_W      9    imem byte-address width; capacity CAP = (2^ADDR_W - BASE_ADDR)/BPW words
//  BASE_ADDR   0    byte address of first word; multiple of BPW
//  CHECKSUM_EN 1    1: trailing checksum byte is required and checked; 0: no checksum byte
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low
//  start      in   1       one-cycle pulse: begin a new load; ignored while busy
//  s_valid    in   1       stream byte valid
//  s_data     in   8       stream byte
//  s_ready    out  1       loader accepts a byte this cycle (transfer = s_valid & s_ready)
//  we0        out  1       imem write enable
//  wr_addr0   out  ADDR_W  imem byte address
//  wr_din0    out  XLEN    imem write data
//  resetpc    out  1       0: CPU PC held in reset; 1: CPU runs
//  busy       out  1       load in progress
//  done       out  1       one-cycle pulse on successful completion
//  err        out  2       sticky: 0 none, 1 length > CAP, 2 checksum mismatch; cleared by start
// BEHAVIOUR
//  Reset: state IDLE; s_ready=0, we0=0, wr_addr0=0, wr_din0=0, resetpc=0, busy=0, done=0, err=0.
//  Frame: LEN (2 bytes, LE, N words) | N*BPW data bytes (LE per word) | CHK byte if CHECKSUM_EN.
//   CHK = 8-bit XOR of all data bytes (LEN bytes excluded); N=0 is legal.
//  FSM:
//   IDLE  : s_ready=0. start -> LEN0; clears err, word index k=0, xor acc=0; resetpc<=0 same edge.
//   LEN0  : s_ready=1; on transfer store N[7:0] -> LEN1.
//   LEN1  : s_ready=1; on transfer store N[15:8]. If N>CAP -> ERR(err=1); else if N==0 -> CHK
//           (or RUN when CHECKSUM_EN=0); else -> DATA.
//   DATA  : s_ready=1; byte j of word placed at bits [8j+7:8j]; acc^=byte; after byte BPW-1 -> WRITE.
//   WRITE : s_ready=0; we0=1 exactly one cycle, wr_addr0=BASE_ADDR+BPW*k, wr_din0=assembled word.
//           k==N-1 -> CHK (or RUN when CHECKSUM_EN=0); else k++ -> DATA.
//   CHK   : s_ready=1; on transfer: byte==acc -> RUN; else -> ERR(err=2).
//   RUN   : resetpc=1, done=1 on entry cycle only; s_ready=0. start -> LEN0 (reload; resetpc=0
//           next cycle, CPU held for entire reload).
//   ERR   : resetpc=0, s_ready=0; stays until start -> LEN0.
//  busy=1 in LEN0,LEN1,DATA,WRITE,CHK. start while busy is ignored.
//  s_valid low stalls any receive state indefinitely; no timeout.
//  Write latency: we0 asserts the cycle after the last byte of a word is accepted.
//  Throughput: one word per BPW+1 cycles at full s_valid rate.
//  wr_addr0/wr_din0 hold last written values outside WRITE; we0=0 outside WRITE.
//  Words written before an error remain in imem; CPU is not released.
//  Address arithmetic is ADDR_W bits; N<=CAP guarantees no wrap.
//  reset low mid-load: immediate return to reset values; partial imem content undefined.
// TESTING
//  1 Default params, start, LEN=0x0003, 12 bytes for 0x00500093,0x00100113,0x002081B3, CHK=XOR
//    -> we0 pulses at addr 0,4,8 with those words; done pulse; resetpc=1; err=0.
//  2 Same frame with CHK^0x01 -> 3 writes occur, then err=2, resetpc stays 0, no done.
//  3 LEN=0x0081 (129 > CAP=128) -> no writes, err=1, s_ready=0; then start + valid frame -> RUN.
//  4 s_valid toggled 1-of-3 cycles during test 1 frame -> identical writes, only timing differs.
//  5 In RUN, start + 1-word frame 0x00000013 -> resetpc 0 next cycle, write addr 0, resetpc 1 again.
//  6 reset driven low mid-DATA -> all outputs to reset values asynchronously; loader in IDLE.

Source files
------------

// File: rtl/imem_stream_loader.sv
// Boot loader: assembles a framed little-endian byte stream into words, writes them through
// the imem preload port, optionally verifies an XOR checksum, then releases the CPU PC.
module imem_stream_loader #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 9,
    parameter int BASE_ADDR   = 0,
    parameter int CHECKSUM_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [XLEN-1:0]   wr_din0,
    output logic              resetpc,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int BPW  = XLEN / 8;
    localparam int CAP  = ((1 << ADDR_W) - BASE_ADDR) / BPW;
    localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(BPW - 1);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BPW_A     = ADDR_W'(BPW);
    localparam logic [16:0]       CAP_L     = 17'(CAP);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHK, S_RUN, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       k_q, k_d;
    logic [BI_W-1:0]   bidx_q, bidx_d;
    logic [XLEN-1:0]   word_q, word_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   din_q, din_d;
    logic [1:0]        err_q, err_d;
    logic              done_q, done_d;

    logic        xfer;
    logic [15:0] len_full;
    state_t      after_data;

    assign xfer       = s_valid & s_ready;
    assign len_full   = {s_data, len_q[7:0]};
    assign after_data = (CHECKSUM_EN != 0) ? S_CHK : S_RUN;

    // NOTE: every always_comb output gets its default before the case; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        k_d     = k_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        acc_d   = acc_q;
        waddr_d = waddr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        err_d   = err_q;
        done_d  = 1'b0;
        s_ready = 1'b0;

        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d = S_LEN0;
                    err_d   = ERR_NONE;
                    k_d     = '0;
                    bidx_d  = '0;
                    acc_d   = '0;
                    waddr_d = BASE_A;
                end
            end
            S_LEN0: begin
                s_ready = 1'b1;
                if (xfer) begin
                    len_d[7:0] = s_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                s_ready = 1'b1;
                if (xfer) begin
                    len_d[15:8] = s_data;
                    if ({1'b0, len_full} > CAP_L) begin
                        state_d = S_ERR;
                        err_d   = ERR_LEN;
                    end else if (len_full == 16'd0) begin
                        state_d = after_data;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                s_ready = 1'b1;
                if (xfer) begin
                    word_d[8*int'(bidx_q) +: 8] = s_data;
                    acc_d = acc_q ^ s_data;
                    if (bidx_q == LAST_BYTE) begin
                        // Latch the completed word and its address so they hold after WRITE.
                        bidx_d  = '0;
                        addr_d  = waddr_q;
                        din_d   = word_d;
                        state_d = S_WRITE;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                waddr_d = waddr_q + BPW_A;
                if (k_q == len_q - 16'd1) begin
                    state_d = after_data;
                end else begin
                    k_d     = k_q + 16'd1;
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
                s_ready = 1'b1;
                if (xfer) begin
                    if (s_data == acc_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERR;
                        err_d   = ERR_CHK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RUN && state_q != S_RUN) done_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            k_q     <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            acc_q   <= '0;
            waddr_q <= BASE_A;
            addr_q  <= '0;
            din_q   <= '0;
            err_q   <= ERR_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            k_q     <= k_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            acc_q   <= acc_d;
            waddr_q <= waddr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign we0      = (state_q == S_WRITE);
    assign resetpc  = (state_q == S_RUN);
    assign busy     = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA) ||
                      (state_q == S_WRITE) || (state_q == S_CHK);
    assign done     = done_q;
    assign err      = err_q;
    assign wr_addr0 = addr_q;
    assign wr_din0  = din_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomised frame bench: a reference model queues the expected imem writes per frame and a
// negedge monitor pops and compares them as the loader pulses we0.
module tb_imem_stream_loader;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 9;
    localparam int BPW    = XLEN / 8;
    localparam int CAP    = (1 << ADDR_W) / BPW;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic              we0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [XLEN-1:0]   wr_din0;
    logic              resetpc;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    imem_stream_loader #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .BASE_ADDR(0), .CHECKSUM_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0),
        .resetpc(resetpc), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
    } wr_t;

    wr_t             exp_q[$];
    logic [XLEN-1:0] fw[$];
    int              tests = 0;
    int              fails = 0;
    int              done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: each we0 cycle must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (we0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         wr_addr0, wr_din0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 64'(wr_addr0), 64'(e.addr));
                check("write_data", 64'(wr_din0), 64'(e.data));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // All drive tasks are entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        budget  = 0;
        while (!s_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!s_ready) check("s_ready_timeout", 64'(s_ready), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_resetpc_low", 64'(resetpc), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
        check("start_err_cleared", 64'(err), 64'd0);
    endtask

    function automatic int pick_gap(input int gap_mode);
        return (gap_mode < 0) ? int'($urandom_range(2, 0)) : gap_mode;
    endfunction

    // Sends one frame built from fw[], N=n, checksum XOR-ed with chk_mask; gap_mode<0 => random.
    task automatic run_frame(input int n, input logic [7:0] chk_mask, input int gap_mode,
                             input string tag);
        logic [7:0] acc;
        logic [1:0] exp_err;
        int         exp_done;
        int         done0;
        int         budget;
        logic [15:0] len;

        len = 16'(n);
        acc = 8'h00;
        for (int i = 0; i < n && n <= CAP; i++)
            for (int j = 0; j < BPW; j++) acc ^= fw[i][8*j +: 8];
        if (n > CAP)              exp_err = 2'd1;
        else if (chk_mask != 8'h00) exp_err = 2'd2;
        else                        exp_err = 2'd0;
        exp_done = (exp_err == 2'd0) ? 1 : 0;
        if (n <= CAP)
            for (int i = 0; i < n; i++) begin
                wr_t w;
                w.addr = ADDR_W'(i * BPW);
                w.data = fw[i];
                exp_q.push_back(w);
            end

        done0 = done_cnt;
        pulse_start();
        send_byte(len[7:0], pick_gap(gap_mode));
        send_byte(len[15:8], pick_gap(gap_mode));
        if (n <= CAP) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < BPW; j++) send_byte(fw[i][8*j +: 8], pick_gap(gap_mode));
            send_byte(acc ^ chk_mask, pick_gap(gap_mode));
        end
        @(negedge clk);
        budget = 0;
        while (busy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_not_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_resetpc"}, 64'(resetpc), 64'(exp_done));
        check({tag, "_done_pulses"}, 64'(done_cnt - done0), 64'(exp_done));
        check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_s_ready_idle"}, 64'(s_ready), 64'd0);
        exp_q.delete();
    endtask

    task automatic load_prog3();
        fw.delete();
        fw.push_back(32'h00500093);
        fw.push_back(32'h00100113);
        fw.push_back(32'h002081B3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_we0"}, 64'(we0), 64'd0);
        check({tag, "_wr_addr0"}, 64'(wr_addr0), 64'd0);
        check({tag, "_wr_din0"}, 64'(wr_din0), 64'd0);
        check({tag, "_resetpc"}, 64'(resetpc), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        load_prog3();
        run_frame(3, 8'h00, 0, "t1_good");
        run_frame(3, 8'h01, 0, "t2_badchk");

        fw.delete();
        run_frame(129, 8'h00, 0, "t3_toolong");
        load_prog3();
        run_frame(3, 8'h00, 0, "t3_recover");

        run_frame(3, 8'h00, 2, "t4_throttled");

        fw.delete();
        fw.push_back(32'h00000013);
        run_frame(1, 8'h00, 0, "t5_reload");

        fw.delete();
        run_frame(0, 8'h00, 0, "n0_good");
        run_frame(0, 8'h5a, 0, "n0_badchk");

        fw.delete();
        for (int i = 0; i < CAP; i++) fw.push_back($urandom());
        run_frame(CAP, 8'h00, 0, "cap_full");

        for (int f = 0; f < 8; f++) begin
            int n;
            logic [7:0] mask;
            n = int'($urandom_range(6, 1));
            mask = ($urandom_range(3, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
            fw.delete();
            for (int i = 0; i < n; i++) fw.push_back($urandom());
            run_frame(n, mask, -1, "rand");
        end

        // Asynchronous reset while the loader is mid-word.
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        check("t6_in_data", 64'(busy & s_ready), 64'd1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("t6_async");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_idle");
        load_prog3();
        run_frame(3, 8'h00, -1, "t6_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
